// File: rtl/bsg_manycore_net_endpoint_pkg.sv
// Shared definitions for the manycore network endpoint: packet opcodes,
// config address, packet width helper and the default-width packet layout.
package bsg_manycore_net_endpoint_pkg;

  typedef enum logic [1:0] {
    OP_NONE         = 2'b00,
    OP_REMOTE_STORE = 2'b01,
    OP_CONFIG       = 2'b10,
    OP_RESERVED     = 2'b11
  } net_op_e;

  // Config packets addressed here carry freeze (data[0]=1) / unfreeze (data[0]=0)
  localparam logic [31:0] CFG_FREEZE_ADDR = '0;

  function automatic int unsigned net_packet_width(input int unsigned x_w,
                                                   input int unsigned y_w,
                                                   input int unsigned addr_w,
                                                   input int unsigned data_w);
    return 2 + data_w / 8 + addr_w + data_w + 2 * (x_w + y_w);
  endfunction

  typedef struct packed {
    net_op_e     op;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  from_y;
    logic [1:0]  from_x;
    logic [1:0]  y_cord;
    logic [1:0]  x_cord;
  } net_packet_default_s;

endpackage

// File: rtl/bsg_manycore_net_endpoint_net_rx_fifo.sv
// Small 1r1w receive FIFO; valid/ready on the write side, valid/yumi on the
// read side. Occupancy count separates full from empty for any depth >= 2.
module net_rx_fifo #(
  parameter int unsigned width_p = 78,
  parameter int unsigned els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] rd_ptr, wr_ptr;
  logic [cnt_w_lp-1:0] count;
  logic                enq, deq;

  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready_o = (count != cnt_w_lp'(els_p));
  assign v_o     = (count != '0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= next_ptr(wr_ptr);
      if (deq) rd_ptr <= next_ptr(rd_ptr);
      unique case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides which entries are live
  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/bsg_manycore_net_endpoint.sv
// Tile network endpoint: buffers and decodes incoming packets at the FIFO
// head, and encodes core data-port remote stores into outgoing packets.
module bsg_manycore_net_endpoint
  import bsg_manycore_net_endpoint_pkg::*;
#(
  parameter int unsigned x_cord_width_p = 2,
  parameter int unsigned y_cord_width_p = 2,
  parameter int unsigned addr_width_p   = 32,
  parameter int unsigned data_width_p   = 32,
  parameter int unsigned fifo_els_p     = 4,
  localparam int unsigned mask_width_lp   = data_width_p / 8,
  localparam int unsigned packet_width_lp =
    net_packet_width(x_cord_width_p, y_cord_width_p, addr_width_p, data_width_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic                       link_v_i,
  input  logic [packet_width_lp-1:0] link_data_i,
  output logic                       link_ready_o,

  input  logic                       decode_en_i,
  input  logic                       store_yumi_i,
  output logic                       remote_store_v_o,
  output logic                       freeze_o,
  output logic                       unfreeze_o,
  output logic                       unknown_o,
  output logic [addr_width_p-1:0]    store_addr_o,
  output logic [data_width_p-1:0]    store_data_o,
  output logic [mask_width_lp-1:0]   store_mask_o,
  output logic [x_cord_width_p-1:0]  from_x_o,
  output logic [y_cord_width_p-1:0]  from_y_o,

  input  logic                       core_v_i,
  input  logic                       core_we_i,
  input  logic [addr_width_p-1:0]    core_addr_i,
  input  logic [data_width_p-1:0]    core_data_i,
  input  logic [mask_width_lp-1:0]   core_mask_i,
  input  logic [x_cord_width_p-1:0]  my_x_i,
  input  logic [y_cord_width_p-1:0]  my_y_i,

  output logic                       out_v_o,
  output logic [packet_width_lp-1:0] out_data_o,
  output logic                       ret_store_cntr_o
);

  localparam int unsigned x_lsb_lp       = 29 - y_cord_width_p - x_cord_width_p + 1;
  localparam int unsigned local_addr_msb_lp = 29 - y_cord_width_p - x_cord_width_p;

  typedef struct packed {
    net_op_e                   op;
    logic [mask_width_lp-1:0]  mask;
    logic [addr_width_p-1:0]   addr;
    logic [data_width_p-1:0]   data;
    logic [y_cord_width_p-1:0] from_y;
    logic [x_cord_width_p-1:0] from_x;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } packet_s;

  logic [packet_width_lp-1:0] head_data;
  packet_s                    head_pkt, out_pkt;
  logic                       fifo_v, fifo_yumi, head_live, core_remote;
  logic                       unused_head_dest;

  net_rx_fifo #(
    .width_p(packet_width_lp),
    .els_p  (fifo_els_p)
  ) rx_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (link_v_i),
    .data_i   (link_data_i),
    .ready_o  (link_ready_o),
    .v_o      (fifo_v),
    .data_o   (head_data),
    .yumi_i   (fifo_yumi)
  );

  assign head_pkt         = packet_s'(head_data);
  assign head_live        = fifo_v & decode_en_i;
  assign unused_head_dest = ^{head_pkt.y_cord, head_pkt.x_cord};

  assign store_addr_o = head_pkt.addr;
  assign store_data_o = head_pkt.data;
  assign store_mask_o = head_pkt.mask;
  assign from_x_o     = head_pkt.from_x;
  assign from_y_o     = head_pkt.from_y;

  always_comb begin
    remote_store_v_o = 1'b0;
    freeze_o         = 1'b0;
    unfreeze_o       = 1'b0;
    unknown_o        = 1'b0;
    if (head_live) begin
      unique case (head_pkt.op)
        OP_REMOTE_STORE: remote_store_v_o = 1'b1;
        OP_CONFIG: begin
          if (head_pkt.addr == addr_width_p'(CFG_FREEZE_ADDR)) begin
            freeze_o   = head_pkt.data[0];
            unfreeze_o = ~head_pkt.data[0];
          end else begin
            unknown_o = 1'b1;
          end
        end
        default: unknown_o = 1'b1;
      endcase
    end
  end

  // Config and unknown packets consume themselves; stores wait for the consumer
  assign fifo_yumi = (remote_store_v_o & store_yumi_i) | freeze_o | unfreeze_o | unknown_o;

  assign core_remote      = core_v_i & core_addr_i[31];
  assign out_v_o          = core_remote & ~core_addr_i[30] & core_we_i;
  assign ret_store_cntr_o = core_remote & core_addr_i[30] & ~core_we_i;

  always_comb begin
    out_pkt        = '0;
    out_pkt.op     = OP_REMOTE_STORE;
    out_pkt.mask   = core_mask_i;
    out_pkt.addr   = addr_width_p'(core_addr_i[local_addr_msb_lp:0]);
    out_pkt.data   = core_data_i;
    out_pkt.from_y = my_y_i;
    out_pkt.from_x = my_x_i;
    out_pkt.y_cord = core_addr_i[29 -: y_cord_width_p];
    out_pkt.x_cord = core_addr_i[x_lsb_lp +: x_cord_width_p];
  end

  assign out_data_o = out_pkt;

endmodule

// File: tb/tb_bsg_manycore_net_endpoint.sv
// Scoreboard bench for bsg_manycore_net_endpoint: accepted packets go into a
// reference queue, a monitor compares the DUT head/encoder against it.
module tb_bsg_manycore_net_endpoint;

  localparam int PW    = 78;
  localparam int DEPTH = 4;

  logic          clk, reset_n;
  logic          link_v, link_ready;
  logic [PW-1:0] link_data;
  logic          decode_en, store_yumi;
  logic          rs_v, frz, unfrz, unk;
  logic [31:0]   st_addr, st_data;
  logic [3:0]    st_mask;
  logic [1:0]    from_x, from_y;
  logic          core_v, core_we;
  logic [31:0]   core_addr, core_data;
  logic [3:0]    core_mask;
  logic [1:0]    my_x, my_y;
  logic          out_v, ret_cntr;
  logic [PW-1:0] out_data;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [PW-1:0] ref_q[$];
  bit            mon_en = 0;

  bsg_manycore_net_endpoint #(
    .x_cord_width_p(2), .y_cord_width_p(2), .addr_width_p(32),
    .data_width_p(32), .fifo_els_p(DEPTH)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .link_v_i(link_v), .link_data_i(link_data), .link_ready_o(link_ready),
    .decode_en_i(decode_en), .store_yumi_i(store_yumi),
    .remote_store_v_o(rs_v), .freeze_o(frz), .unfreeze_o(unfrz), .unknown_o(unk),
    .store_addr_o(st_addr), .store_data_o(st_data), .store_mask_o(st_mask),
    .from_x_o(from_x), .from_y_o(from_y),
    .core_v_i(core_v), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_data_i(core_data), .core_mask_i(core_mask),
    .my_x_i(my_x), .my_y_i(my_y),
    .out_v_o(out_v), .out_data_o(out_data), .ret_store_cntr_o(ret_cntr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk_pkt(input logic [1:0] op, input logic [3:0] mask,
                                           input logic [31:0] addr, input logic [31:0] data,
                                           input logic [1:0] fx, input logic [1:0] fy,
                                           input logic [1:0] x, input logic [1:0] y);
    return {op, mask, addr, data, fy, fx, y, x};
  endfunction

  function automatic logic [PW-1:0] rand_pkt();
    logic [31:0] a;
    a = ($urandom_range(0, 1) == 1) ? 32'h0 : $urandom;
    return mk_pkt(2'($urandom_range(0, 3)), 4'($urandom), a, $urandom,
                  2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
  endfunction

  // Monitor: reference head decode, dequeue rule and encoder, from packet fields
  always begin
    logic [PW-1:0] h;
    logic [1:0]    op;
    bit            has, es, ef, eu, ek, ev, er;
    @(negedge clk);
    #1;
    if (mon_en) begin
      chk("link_ready", link_ready, ref_q.size() < DEPTH);
      has = ref_q.size() != 0;
      es = 0; ef = 0; eu = 0; ek = 0;
      h  = '0;
      if (has) h = ref_q[0];
      op = h[77:76];
      if (has && decode_en) begin
        if (op == 2'b01) es = 1;
        else if (op == 2'b10 && h[71:40] == 32'h0) begin
          if (h[8]) ef = 1; else eu = 1;
        end else ek = 1;
      end
      chk("kinds{store,frz,unfrz,unk}", {rs_v, frz, unfrz, unk}, {es, ef, eu, ek});
      if (has) begin
        chk("store_addr", st_addr, h[71:40]);
        chk("store_data", st_data, h[39:8]);
        chk("store_mask", st_mask, h[75:72]);
        chk("from_xy", {from_y, from_x}, h[7:4]);
      end
      if (ef || eu || ek || (es && store_yumi)) void'(ref_q.pop_front());

      ev = core_v && core_addr[31] && !core_addr[30] && core_we;
      er = core_v && core_addr[31] && core_addr[30] && !core_we;
      chk("out_v", out_v, ev);
      chk("ret_store_cntr", ret_cntr, er);
      if (ev)
        chk("out_data", out_data,
            mk_pkt(2'b01, core_mask, {6'b0, core_addr[25:0]}, core_data,
                   my_x, my_y, core_addr[27:26], core_addr[29:28]));
    end
  end

  task automatic step(input bit lv, input logic [PW-1:0] pkt, input bit en, input bit yumi);
    @(negedge clk);
    link_v     = lv;
    link_data  = pkt;
    decode_en  = en;
    store_yumi = yumi;
    #2;
    if (lv && link_ready && reset_n) ref_q.push_back(pkt);
  endtask

  task automatic set_core(input bit v, input bit we, input logic [31:0] a);
    core_v    = v;
    core_we   = we;
    core_addr = a;
    core_data = $urandom;
    core_mask = 4'($urandom);
  endtask

  initial begin
    reset_n = 1'b0;
    link_v = 0; link_data = '0; decode_en = 1; store_yumi = 0;
    my_x = 2'd2; my_y = 2'd1;
    set_core(0, 0, 32'h0);

    repeat (2) @(negedge clk);
    #1;
    chk("reset_ready", link_ready, 1'b1);
    chk("reset_kinds", {rs_v, frz, unfrz, unk}, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1;

    // Single store, then consume it
    step(1, mk_pkt(2'b01, 4'hF, 32'h10, 32'hDEADBEEF, 2'd1, 2'd2, 2'd0, 2'd0), 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 1);
    step(0, '0, 1, 0);

    // Fill with decode held off, then release one and drain
    for (int i = 0; i < DEPTH; i++)
      step(1, mk_pkt(2'b01, 4'(i), 32'(i * 4), $urandom, 2'(i), 2'(i), 2'd0, 2'd0), 0, 1);
    step(1, rand_pkt(), 0, 1);
    step(1, rand_pkt(), 1, 1);
    step(0, '0, 1, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(0, '0, 1, 1);

    // Freeze, unfreeze, unknown op, unknown config address
    step(1, mk_pkt(2'b10, 4'h0, 32'h0, 32'h1, 2'd3, 2'd3, 2'd0, 2'd0), 1, 0);
    step(1, mk_pkt(2'b10, 4'h0, 32'h0, 32'h0, 2'd1, 2'd0, 2'd0, 2'd0), 1, 0);
    step(1, mk_pkt(2'b11, 4'h5, 32'h0, 32'h1, 2'd0, 2'd1, 2'd0, 2'd0), 1, 0);
    step(1, mk_pkt(2'b10, 4'h0, 32'h4, 32'h1, 2'd0, 2'd1, 2'd0, 2'd0), 1, 0);
    repeat (4) step(0, '0, 1, 0);

    // Encoder corner cases
    set_core(1, 1, 32'hB400_0004); step(0, '0, 1, 0);
    set_core(1, 0, 32'hB400_0004); step(0, '0, 1, 0);
    set_core(1, 0, 32'hC000_0000); step(0, '0, 1, 0);
    set_core(1, 1, 32'hC000_0000); step(0, '0, 1, 0);
    set_core(1, 1, 32'h0000_0100); step(0, '0, 1, 0);
    set_core(1, 0, 32'h0000_0100); step(0, '0, 1, 0);
    set_core(0, 1, 32'h8000_0004); step(0, '0, 1, 0);

    // Randomized traffic in fill-heavy, drain-heavy and balanced phases
    for (int i = 0; i < 3000; i++) begin
      int phase;
      phase = (i / 150) % 3;
      set_core($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom);
      my_x = 2'($urandom);
      my_y = 2'($urandom);
      if (i == 1500) begin
        repeat (3) step(1, rand_pkt(), 0, 0);
        reset_n = 1'b0;
        ref_q.delete();
        #1;
        chk("midreset_ready", link_ready, 1'b1);
        chk("midreset_kinds", {rs_v, frz, unfrz, unk}, 4'b0000);
        repeat (2) step(0, '0, 1, 1);
        reset_n = 1'b1;
      end
      case (phase)
        0:       step($urandom_range(0, 9) != 0, rand_pkt(), $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
        1:       step($urandom_range(0, 4) == 0, rand_pkt(), $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0);
        default: step($urandom_range(0, 1) == 1, rand_pkt(), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      endcase
    end

    @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
